// File: rtl/dice_game_ctrl.sv
// Craps-style dice game controller: a held roll button spins two dice, and
// releasing it after a long enough hold captures and scores the throw.
module dice_game_ctrl #(
    parameter int MIN_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       roll,
    input  logic       new_game,
    output logic [2:0] die1,
    output logic [2:0] die2,
    output logic [3:0] sum,
    output logic [3:0] point,
    output logic       win,
    output logic       lose,
    output logic       busy
);

    localparam int HW = (MIN_HOLD < 2) ? 1 : $clog2(MIN_HOLD + 1);

    typedef enum logic [2:0] {
        FIRST, ROLL1, EVAL1, POINT, ROLLN, EVALN, WIN, LOSE
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [3:0]    dice_sum;
    logic [2:0]    die1_next;
    logic [2:0]    die2_next;
    logic          hold_ok;

    assign dice_sum  = {1'b0, die1} + {1'b0, die2};
    assign die1_next = (die1 == 3'd6) ? 3'd1 : die1 + 3'd1;
    assign die2_next = (die2 == 3'd6) ? 3'd1 : die2 + 3'd1;
    assign hold_ok   = (hold_cnt >= HW'(MIN_HOLD));

    // The dice spin only while the button is held, so the faces shown after a
    // release are exactly the faces that were scored (or discarded).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FIRST;
            die1     <= 3'd1;
            die2     <= 3'd1;
            sum      <= 4'd0;
            point    <= 4'd0;
            win      <= 1'b0;
            lose     <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else if (new_game) begin
            state    <= FIRST;
            sum      <= 4'd0;
            point    <= 4'd0;
            win      <= 1'b0;
            lose     <= 1'b0;
            busy     <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                FIRST, POINT: begin
                    if (roll) begin
                        state    <= (state == FIRST) ? ROLL1 : ROLLN;
                        hold_cnt <= HW'(1);
                        busy     <= 1'b1;
                    end
                end
                ROLL1, ROLLN: begin
                    if (roll) begin
                        die1 <= die1_next;
                        if (die1 == 3'd6)
                            die2 <= die2_next;
                        if (!hold_ok)
                            hold_cnt <= hold_cnt + HW'(1);
                    end else if (hold_ok) begin
                        sum   <= dice_sum;
                        state <= (state == ROLL1) ? EVAL1 : EVALN;
                    end else begin
                        state <= (state == ROLL1) ? FIRST : POINT;
                        busy  <= 1'b0;
                    end
                end
                EVAL1: begin
                    busy <= 1'b0;
                    case (sum)
                        4'd7, 4'd11: begin
                            state <= WIN;
                            win   <= 1'b1;
                        end
                        4'd2, 4'd3, 4'd12: begin
                            state <= LOSE;
                            lose  <= 1'b1;
                        end
                        default: begin
                            point <= sum;
                            state <= POINT;
                        end
                    endcase
                end
                EVALN: begin
                    busy <= 1'b0;
                    if (sum == point) begin
                        state <= WIN;
                        win   <= 1'b1;
                    end else if (sum == 4'd7) begin
                        state <= LOSE;
                        lose  <= 1'b1;
                    end else begin
                        state <= POINT;
                    end
                end
                WIN, LOSE: begin
                    state <= state;
                end
                default: begin
                    state <= FIRST;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
